alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_pkg.sv | 53 +++++
 rtl/alu_funct_decode.sv | 43 ++++
 rtl/alu_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared funct codes, ALU select codes and FSM states for alu_issue_ctrl
package alu_issue_pkg;

   // MIPS R-type funct codes accepted by the issue controller
   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_MULT = 6'b011000;
   localparam logic [5:0] FUNCT_DIV  = 6'b011010;
   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_XOR  = 6'b100110;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;

   // Select codes understood by the external ALU
   localparam logic [4:0] SEL_ADD  = 5'b00000;
   localparam logic [4:0] SEL_SUB  = 5'b00001;
   localparam logic [4:0] SEL_MULT = 5'b00010;
   localparam logic [4:0] SEL_DIV  = 5'b00011;
   localparam logic [4:0] SEL_SLL  = 5'b00100;
   localparam logic [4:0] SEL_SRL  = 5'b00101;
   localparam logic [4:0] SEL_AND  = 5'b01000;
   localparam logic [4:0] SEL_OR   = 5'b01001;
   localparam logic [4:0] SEL_XOR  = 5'b01010;
   localparam logic [4:0] SEL_NOR  = 5'b01011;
   localparam logic [4:0] SEL_SLT  = 5'b01110;

   // Result of a divide-by-zero when it is short-circuited around the ALU
   localparam logic [31:0] DIVZERO_RESULT = 32'hFFFF_FFFF;

   // Issue controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Where the result of a single-cycle completion comes from
   typedef enum logic [1:0] {
      SRC_ALU     = 2'd0,
      SRC_ILLEGAL = 2'd1,
      SRC_DIVZERO = 2'd2
   } res_src_t;

   // True for a divide whose divisor is zero
   function automatic logic is_div_by_zero(input logic [4:0] sel, input logic [31:0] divisor);
      return (sel == SEL_DIV) && (divisor == 32'd0);
   endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// rtl/alu_funct_decode.sv - combinational funct to ALU select decoder
module alu_funct_decode
   import alu_issue_pkg::*;
(
   input  logic [5:0] funct,
   output logic [4:0] sel,
   output logic       swap,
   output logic       muldiv,
   output logic       illegal
);

   // Map funct to ALU select; slt swaps operands so the ALU greater-than yields a<b
   always_comb begin
      sel     = SEL_ADD;
      swap    = 1'b0;
      muldiv  = 1'b0;
      illegal = 1'b0;
      case (funct)
         FUNCT_ADD:  sel = SEL_ADD;
         FUNCT_SUB:  sel = SEL_SUB;
         FUNCT_MULT: begin
            sel    = SEL_MULT;
            muldiv = 1'b1;
         end
         FUNCT_DIV:  begin
            sel    = SEL_DIV;
            muldiv = 1'b1;
         end
         FUNCT_SLL:  sel = SEL_SLL;
         FUNCT_SRL:  sel = SEL_SRL;
         FUNCT_AND:  sel = SEL_AND;
         FUNCT_OR:   sel = SEL_OR;
         FUNCT_XOR:  sel = SEL_XOR;
         FUNCT_NOR:  sel = SEL_NOR;
         FUNCT_SLT:  begin
            sel  = SEL_SLT;
            swap = 1'b1;
         end
         default:    illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue controller between a request stream and an external ALU
// Optional: ALU_ISSUE_DIVZERO_EN completes div by zero in one cycle with an all-ones result.
module alu_issue_ctrl
   import alu_issue_pkg::*;
#(
   parameter int MULDIV_LAT = 4   // ALU settle cycles for mult/div, legal 1..15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  in_funct,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_sel,
   input  logic [31:0] alu_out,
   input  logic        alu_carry,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_carry,
   output logic        out_illegal
);

   if (MULDIV_LAT < 1 || MULDIV_LAT > 15) begin : g_bad_lat
      $error("MULDIV_LAT must be in 1..15");
   end

   localparam logic [3:0] LAT_LOAD = 4'(MULDIV_LAT);

   logic [4:0]  w_sel;
   logic        w_swap;
   logic        w_muldiv;
   logic        w_illegal;
   logic        w_divzero;
   res_src_t    w_src;

   state_t      r_state;
   logic [3:0]  r_cnt;
   res_src_t    r_src;
   logic        r_in_ready;
   logic [31:0] r_alu_a;
   logic [31:0] r_alu_b;
   logic [4:0]  r_alu_sel;
   logic        r_out_valid;
   logic [31:0] r_out_result;
   logic        r_out_carry;
   logic        r_out_illegal;

   alu_funct_decode u_decode (
      .funct   (in_funct),
      .sel     (w_sel),
      .swap    (w_swap),
      .muldiv  (w_muldiv),
      .illegal (w_illegal)
   );

`ifdef ALU_ISSUE_DIVZERO_EN
   assign w_divzero = is_div_by_zero(w_sel, in_b);
`else
   assign w_divzero = 1'b0;
`endif

   // Pick how a single-cycle completion will form its result
   always_comb begin
      w_src = SRC_ALU;
      if (w_illegal) begin
         w_src = SRC_ILLEGAL;
      end else if (w_divzero) begin
         w_src = SRC_DIVZERO;
      end
   end

   // Issue FSM: accept in IDLE, settle in EXEC/WAIT, present result in DONE until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= 4'd0;
         r_src         <= SRC_ALU;
         r_in_ready    <= 1'b1;
         r_alu_a       <= 32'd0;
         r_alu_b       <= 32'd0;
         r_alu_sel     <= 5'd0;
         r_out_valid   <= 1'b0;
         r_out_result  <= 32'd0;
         r_out_carry   <= 1'b0;
         r_out_illegal <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_in_ready <= 1'b0;
                  r_alu_a    <= w_swap ? in_b : in_a;
                  r_alu_b    <= w_swap ? in_a : in_b;
                  r_alu_sel  <= w_sel;
                  r_src      <= w_src;
                  if (w_muldiv && !w_divzero) begin
                     r_cnt   <= LAT_LOAD;
                     r_state <= ST_WAIT;
                  end else begin
                     r_state <= ST_EXEC;
                  end
               end
            end
            ST_EXEC: begin
               r_out_valid <= 1'b1;
               r_state     <= ST_DONE;
               case (r_src)
                  SRC_ILLEGAL: begin
                     r_out_result  <= 32'd0;
                     r_out_carry   <= 1'b0;
                     r_out_illegal <= 1'b1;
                  end
                  SRC_DIVZERO: begin
                     r_out_result  <= DIVZERO_RESULT;
                     r_out_carry   <= 1'b0;
                     r_out_illegal <= 1'b1;
                  end
                  default: begin
                     r_out_result  <= alu_out;
                     r_out_carry   <= alu_carry;
                     r_out_illegal <= 1'b0;
                  end
               endcase
            end
            ST_WAIT: begin
               // The counter reaches one on the cycle before the ALU has settled
               if (r_cnt <= 4'd1) begin
                  r_cnt         <= 4'd0;
                  r_out_valid   <= 1'b1;
                  r_out_result  <= alu_out;
                  r_out_carry   <= alu_carry;
                  r_out_illegal <= 1'b0;
                  r_state       <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_in_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign alu_a       = r_alu_a;
   assign alu_b       = r_alu_b;
   assign alu_sel     = r_alu_sel;
   assign out_valid   = r_out_valid;
   assign out_result  = r_out_result;
   assign out_carry   = r_out_carry;
   assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a behavioural ALU stub
module tb_alu_issue_ctrl;

   localparam int LAT = 4;

   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_DIV  = 6'b011010;
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;

   localparam logic [31:0] DIVZ_ALU = 32'h0BAD_D170;
   localparam logic [31:0] UNSETTLED = 32'hBADC_0FFE;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_funct;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  alu_sel;
   logic [31:0] alu_out;
   logic        alu_carry;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_carry;
   logic        out_illegal;

   logic        rand_ready = 1'b0;
   logic        rnd_ready = 1'b1;
   logic        force_ready = 1'b1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] res;
      logic        carry;
      logic        ill;
      int          lat;
      logic [4:0]  sel;
      longint      t;
   } exp_t;

   exp_t sb_q[$];

   logic [5:0] legal_f [11] = '{F_ADD, F_SUB, F_MULT, F_DIV, F_SLL, F_SRL,
                                F_AND, F_OR, F_XOR, F_NOR, F_SLT};
   logic [5:0] bad_f [4] = '{6'h3F, 6'h01, 6'h21, 6'h2B};

   always #5 clk = ~clk;

   assign out_ready = rand_ready ? rnd_ready : force_ready;

   alu_issue_ctrl #(.MULDIV_LAT(LAT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_funct    (in_funct),
      .in_a        (in_a),
      .in_b        (in_b),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_sel     (alu_sel),
      .alu_out     (alu_out),
      .alu_carry   (alu_carry),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_carry   (out_carry),
      .out_illegal (out_illegal)
   );

   // ALU stub: mult/div only give a meaningful answer after LAT cycles of stable inputs
   int          settle = 0;
   logic [68:0] prev_in = '1;

   initial forever begin
      @(negedge clk);
      if ({alu_a, alu_b, alu_sel} != prev_in) begin
         prev_in = {alu_a, alu_b, alu_sel};
         settle  = 1;
      end else if (settle < 1000) begin
         settle = settle + 1;
      end
   end

   always_comb begin
      alu_out   = 32'd0;
      alu_carry = 1'b0;
      case (alu_sel)
         5'd0:  {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         5'd1:  begin alu_out = alu_a - alu_b; alu_carry = (alu_b > alu_a); end
         5'd2:  alu_out = (settle >= LAT) ? alu_a * alu_b : UNSETTLED;
         5'd3:  alu_out = (settle < LAT) ? UNSETTLED : (alu_b == 32'd0) ? DIVZ_ALU : alu_a / alu_b;
         5'd4:  alu_out = alu_a << alu_b[4:0];
         5'd5:  alu_out = alu_a >> alu_b[4:0];
         5'd8:  alu_out = alu_a & alu_b;
         5'd9:  alu_out = alu_a | alu_b;
         5'd10: alu_out = alu_a ^ alu_b;
         5'd11: alu_out = ~(alu_a | alu_b);
         5'd14: alu_out = {31'd0, $signed(alu_a) > $signed(alu_b)};
         default: alu_out = 32'd0;
      endcase
   end

   // Reference model: what the request means, independent of how the controller sequences it
   function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [63:0] wide;
      e.res = 32'd0; e.carry = 1'b0; e.ill = 1'b0; e.lat = 1; e.sel = 5'd0; e.t = 0;
      case (f)
         F_ADD:  begin wide = 64'(a) + 64'(b); e.res = wide[31:0]; e.carry = wide[32]; e.sel = 5'd0; end
         F_SUB:  begin e.res = a - b; e.carry = (a < b); e.sel = 5'd1; end
         F_MULT: begin wide = 64'(a) * 64'(b); e.res = wide[31:0]; e.lat = LAT; e.sel = 5'd2; end
         F_DIV:  begin
            e.sel = 5'd3;
            if (b == 32'd0) begin
`ifdef ALU_ISSUE_DIVZERO_EN
               e.res = 32'hFFFF_FFFF; e.ill = 1'b1; e.lat = 1;
`else
               e.res = DIVZ_ALU; e.lat = LAT;
`endif
            end else begin
               e.res = a / b; e.lat = LAT;
            end
         end
         F_SLL:  begin e.res = a << (b % 32); e.sel = 5'd4; end
         F_SRL:  begin e.res = a >> (b % 32); e.sel = 5'd5; end
         F_AND:  begin e.res = a & b; e.sel = 5'd8; end
         F_OR:   begin e.res = a | b; e.sel = 5'd9; end
         F_XOR:  begin e.res = a ^ b; e.sel = 5'd10; end
         F_NOR:  begin e.res = ~(a | b); e.sel = 5'd11; end
         F_SLT:  begin e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.sel = 5'd14; end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      errors++;
      $display("FAIL %s: %s at %0t", name, what, $time);
   endtask

   // Present a request (called 2ns after a rising edge); returns 2ns after the accepting edge
   task automatic send(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic rdy;
      logic got;
      exp_t e;
      got = 1'b0;
      in_funct = f; in_a = a; in_b = b; in_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rdy = in_ready;
         @(posedge clk);
         if (rdy) begin
            got = 1'b1;
            e = model(f, a, b);
            e.t = longint'($time);
            sb_q.push_back(e);
         end
         #2;
         if (got) break;
      end
      in_valid = 1'b0;
      in_funct = 6'($urandom); in_a = $urandom; in_b = $urandom;
      if (!got) begin
         fail_now("accept_timeout", "in_ready never high, required accept within 300 cycles");
      end else begin
         e = model(f, a, b);
         check("alu_sel", 32'(alu_sel), 32'(e.sel));
         if (!e.ill || f == F_DIV) begin
            check("alu_a", alu_a, (f == F_SLT) ? b : a);
            check("alu_b", alu_b, (f == F_SLT) ? a : b);
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 400) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 400) fail_now("drain_timeout", "results outstanding after 400 cycles, required none");
   endtask

   // Monitor: pops the scoreboard on each new result and checks hold/drop behaviour
   initial begin
      logic        prev_v;
      logic        expect_low;
      logic        stab_bad;
      logic [31:0] held_res;
      logic        held_c;
      logic        held_i;
      exp_t        e;
      longint      lat_act;
      prev_v = 1'b0; expect_low = 1'b0; stab_bad = 1'b0;
      held_res = 32'd0; held_c = 1'b0; held_i = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_v = 1'b0; expect_low = 1'b0; stab_bad = 1'b0;
         end else begin
            if (expect_low) begin
               check("valid_drop", 32'(out_valid), 32'd0);
               expect_low = 1'b0;
            end
            if (out_valid && !prev_v) begin
               if (sb_q.size() == 0) begin
                  fail_now("spurious_result", $sformatf("out_valid=1 result=%h, required no result", out_result));
               end else begin
                  e = sb_q.pop_front();
                  lat_act = (longint'($time) - e.t - 5) / 10;
                  check("out_result", out_result, e.res);
                  check("out_carry", 32'(out_carry), 32'(e.carry));
                  check("out_illegal", 32'(out_illegal), 32'(e.ill));
                  check("latency", 32'(lat_act), 32'(e.lat));
                  check("sel_held", 32'(alu_sel), 32'(e.sel));
                  check("busy_ready", 32'(in_ready), 32'd0);
               end
               held_res = out_result; held_c = out_carry; held_i = out_illegal;
               stab_bad = 1'b0;
            end else if (out_valid) begin
               if (out_result !== held_res || out_carry !== held_c || out_illegal !== held_i)
                  stab_bad = 1'b1;
            end
            if (out_valid && out_ready) begin
               check("hold_stable", 32'(stab_bad), 32'd0);
               expect_low = 1'b1;
               prev_v = 1'b0;
            end else begin
               prev_v = out_valid;
            end
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       bad;
      logic [5:0] f;
      logic [31:0] a;
      logic [31:0] b;
      rst_n = 1'b0; in_valid = 1'b0; in_funct = 6'd0; in_a = 32'd0; in_b = 32'd0;
      force_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out", {out_result[29:0], out_carry, out_illegal}, 32'd0);
      check("rst_alu", alu_a | alu_b | 32'(alu_sel), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      send(F_ADD, 32'd5, 32'd7);
      send(F_SLT, 32'd3, 32'd9);
      send(F_SLT, 32'd9, 32'd3);
      send(F_SLT, 32'hFFFF_FFFF, 32'd1);
      drain();

      send(F_MULT, 32'd6, 32'd7);
      bad = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         @(posedge clk); #2;
         if (in_ready) bad = 1'b1;
      end
      check("mult_ready_low", 32'(bad), 32'd0);
      drain();

      send(6'h3F, 32'd1, 32'd2);
      send(F_DIV, 32'd8, 32'd0);
      send(F_DIV, 32'd100, 32'd7);
      send(F_SUB, 32'd3, 32'd5);
      drain();

      // Backpressure: result held, second request waits
      force_ready = 1'b0;
      send(F_ADD, 32'hFFFF_FFFF, 32'd1);
      in_funct = F_OR; in_a = 32'h00F0_0000; in_b = 32'h0000_0F0F; in_valid = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #2;
         if (in_ready || (i > 0 && !out_valid)) bad = 1'b1;
      end
      check("bp_blocked", 32'(bad), 32'd0);
      force_ready = 1'b1;
      @(posedge clk); #2;
      check("bp_idle_ready", 32'(in_ready), 32'd1);
      check("bp_idle_valid", 32'(out_valid), 32'd0);
      send(F_OR, 32'h00F0_0000, 32'h0000_0F0F);
      drain();

      // Reset mid-WAIT discards the request
      send(F_MULT, 32'd11, 32'd13);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out", out_result | 32'(out_carry) | 32'(out_illegal), 32'd0);
      check("midrst_alu", alu_a | alu_b | 32'(alu_sel), 32'd0);
      sb_q.delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < LAT + 4; i++) begin
         @(posedge clk); #2;
         if (out_valid) bad = 1'b1;
      end
      check("midrst_no_result", 32'(bad), 32'd0);

      // Randomised traffic with random consumer backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 150; n++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
         if ($urandom_range(0, 9) == 0) f = bad_f[$urandom_range(0, 3)];
         else f = legal_f[$urandom_range(0, 10)];
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 32'd0;
            1: b = 32'($urandom_range(0, 40));
            default: b = $urandom;
         endcase
         send(f, a, b);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
